// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider: operation codes and FSM states.
// Also holds the op-decoding helpers used by both the top and the bench.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit 0 clear selects the signed flavour, bit 1 set selects the remainder.
  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Shifts {rem,quo} left, trial-subtracts the divisor on WIDTH+1 bits, keeps or restores.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  // A set top bit means the trial went negative, so the shifted value is restored.
  assign rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned divider: WIDTH+2 cycles start-to-done, 1 cycle for /0 and overflow.
// Backpressure: start is ignored unless idle; flush aborts and leaves result untouched.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             is_rem, neg_q, neg_r;

  logic             sgn, div_zero, ovf, special;
  logic [WIDTH-1:0] abs_a, abs_b, special_val, fix_q, fix_r;

  assign sgn      = op_signed(op);
  assign div_zero = (divisor == '0);
  assign ovf      = sgn && (dividend == MOST_NEG) && (divisor == '1);
  assign special  = div_zero | ovf;

  assign abs_a = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Divide-by-zero takes precedence; the overflow case can never have a zero divisor anyway.
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = op_rem(op) ? dividend : '1;
    else
      special_val = op_rem(op) ? '0 : dividend;
  end

  assign fix_q = neg_q ? -quo : quo;
  assign fix_r = neg_r ? -rem : rem;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == '0) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            is_rem <= op_rem(op);
            neg_q  <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r  <= sgn && dividend[WIDTH-1];
            rem    <= '0;
            quo    <= abs_a;
            dvs    <= abs_b;
            cnt    <= CW'(WIDTH-1);
            if (special) result <= special_val;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX:     result <= is_rem ? fix_r : fix_q;
        default: ;
      endcase
    end
  end

endmodule
